// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered, locked grant and a valid/ready handshake.
// The priority pointer advances past the winner only when a grant is accepted.
module rr_grant_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = (NUM_REQ == 1) ? 1 : $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_i,
    output logic [NUM_REQ-1:0]   gnt_onehot_o,
    output logic [IDX_WIDTH-1:0] gnt_idx_o,
    output logic                 gnt_valid_o,
    input  logic                 gnt_ready_i
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_onehot_q, gnt_onehot_d;
    logic [IDX_WIDTH-1:0] gnt_idx_q, gnt_idx_d;

    logic                 handshake;
    logic                 found;
    int unsigned          next_ptr;
    int unsigned          base;
    int unsigned          win;
    logic [NUM_REQ-1:0]   win_onehot;

    // Circular first-set search starting at the pointer that applies this edge.
    // Two linear passes (base..N-1, then 0..base-1) replace a modulo rotation.
    always_comb begin
        handshake  = (state_q == GRANT) && gnt_ready_i;
        next_ptr   = 32'(gnt_idx_q) + 1;
        if (next_ptr >= NUM_REQ) begin
            next_ptr = 0;
        end
        base       = handshake ? next_ptr : 32'(ptr_q);
        found      = 1'b0;
        win        = 0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i] && (i >= base)) begin
                found = 1'b1;
                win   = i;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[i]) begin
                found = 1'b1;
                win   = i;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = found && (i == win);
        end
    end

    // Next-state and next-output logic: load on request, hold while stalled,
    // re-arbitrate or drop to idle on an accepted grant.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_onehot_d = gnt_onehot_q;
        gnt_idx_d    = gnt_idx_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANT;
                    gnt_onehot_d = win_onehot;
                    gnt_idx_d    = win[IDX_WIDTH-1:0];
                end else begin
                    gnt_onehot_d = '0;
                    gnt_idx_d    = '0;
                end
            end
            GRANT: begin
                if (handshake) begin
                    ptr_d = next_ptr[IDX_WIDTH-1:0];
                    if (found) begin
                        gnt_onehot_d = win_onehot;
                        gnt_idx_d    = win[IDX_WIDTH-1:0];
                    end else begin
                        state_d      = IDLE;
                        gnt_onehot_d = '0;
                        gnt_idx_d    = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_onehot_q <= '0;
            gnt_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_onehot_q <= gnt_onehot_d;
            gnt_idx_q    <= gnt_idx_d;
        end
    end

    assign gnt_onehot_o = gnt_onehot_q;
    assign gnt_idx_o    = gnt_idx_q;
    assign gnt_valid_o  = (state_q == GRANT);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: a 4-requester and a 3-requester
// instance, directed scenarios followed by random traffic, each cycle checked
// against a behavioural round-robin model.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req4;
    logic       rdy4;
    logic [3:0] oh4;
    logic [1:0] idx4;
    logic       v4;
    logic [2:0] req3;
    logic       rdy3;
    logic [2:0] oh3;
    logic [1:0] idx3;
    logic       v3;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state, index 0 = 4-requester, index 1 = 3-requester
    int m_valid [2];
    int m_idx   [2];
    int m_ptr   [2];

    always #5 clk = ~clk;

    rr_grant_arbiter #(.NUM_REQ(4)) dut4 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req4),
        .gnt_onehot_o (oh4),
        .gnt_idx_o    (idx4),
        .gnt_valid_o  (v4),
        .gnt_ready_i  (rdy4)
    );

    rr_grant_arbiter #(.NUM_REQ(3)) dut3 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req3),
        .gnt_onehot_o (oh3),
        .gnt_idx_o    (idx3),
        .gnt_valid_o  (v3),
        .gnt_ready_i  (rdy3)
    );

    function automatic int arb(input logic [31:0] req, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (ptr + k) % n;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_step(input int u, input logic rst, input logic [31:0] req,
                                       input logic rdy, input int n);
        int w;
        if (!rst) begin
            m_valid[u] = 0;
            m_idx[u]   = 0;
            m_ptr[u]   = 0;
        end else if (m_valid[u] == 0) begin
            w = arb(req, m_ptr[u], n);
            if (w >= 0) begin
                m_valid[u] = 1;
                m_idx[u]   = w;
            end
        end else if (rdy) begin
            m_ptr[u] = (m_idx[u] + 1) % n;
            w = arb(req, m_ptr[u], n);
            if (w >= 0) begin
                m_idx[u] = w;
            end else begin
                m_valid[u] = 0;
                m_idx[u]   = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("n4_valid",  32'(v4),   32'(m_valid[0]));
        chk("n4_idx",    32'(idx4), 32'(m_idx[0]));
        chk("n4_onehot", 32'(oh4),  m_valid[0] != 0 ? (32'd1 << m_idx[0]) : 32'd0);
        chk("n3_valid",  32'(v3),   32'(m_valid[1]));
        chk("n3_idx",    32'(idx3), 32'(m_idx[1]));
        chk("n3_onehot", 32'(oh3),  m_valid[1] != 0 ? (32'd1 << m_idx[1]) : 32'd0);
    endtask

    // Advance one clock, update the model with the inputs seen at that edge,
    // then compare just after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0, rst_n, 32'(req4), rdy4, 4);
        model_step(1, rst_n, 32'(req3), rdy3, 3);
        #1;
        chk_model();
    endtask

    initial begin
        int exp_seq4 [5];
        int exp_seq3 [4];
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = 0;
            m_idx[u]   = 0;
            m_ptr[u]   = 0;
        end
        rst_n = 1'b0; req4 = 4'b1111; rdy4 = 1'b1; req3 = '0; rdy3 = 1'b0;

        // Reset with all requests asserted
        cycle();
        cycle();
        chk("rst_onehot", 32'(oh4), 32'd0);
        chk("rst_valid",  32'(v4),  32'd0);

        // Release: first grant to requester 0 one cycle later
        rst_n = 1'b1;
        cycle();
        chk("first_onehot", 32'(oh4), 32'b0001);
        chk("first_idx",    32'(idx4), 32'd0);

        // Fairness under continuous ready
        exp_seq4 = '{1, 2, 3, 0, 1};
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("fair_idx",   32'(idx4), 32'(exp_seq4[k]));
            chk("fair_valid", 32'(v4),   32'd1);
        end

        // Drain, then backpressure with grant lock
        req4 = 4'b0000; rdy4 = 1'b1;
        cycle();
        chk("drain_valid", 32'(v4), 32'd0);
        req4 = 4'b0100; rdy4 = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) req4 = 4'b0000;
            cycle();
            chk("lock_onehot", 32'(oh4),  32'b0100);
            chk("lock_idx",    32'(idx4), 32'd2);
        end
        rdy4 = 1'b1;
        cycle();
        chk("release_valid", 32'(v4), 32'd0);

        // Wrap past the last requester
        req4 = 4'b1000;
        cycle();
        chk("wrap_pre_idx", 32'(idx4), 32'd3);
        req4 = 4'b1001;
        cycle();
        chk("wrap_idx0", 32'(idx4), 32'd0);
        cycle();
        chk("wrap_idx3", 32'(idx4), 32'd3);

        // Reset in the middle of a grant
        req4 = 4'b0000;
        cycle();
        req4 = 4'b0100; rdy4 = 1'b0;
        cycle();
        chk("mid_pre_idx", 32'(idx4), 32'd2);
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_valid",  32'(v4),  32'd0);
        chk("mid_rst_onehot", 32'(oh4), 32'd0);
        rst_n = 1'b1; req4 = 4'b1111;
        cycle();
        chk("mid_after_idx", 32'(idx4), 32'd0);

        // Non-power-of-two instance
        req4 = '0; rdy4 = 1'b1;
        req3 = 3'b111; rdy3 = 1'b1;
        exp_seq3 = '{0, 1, 2, 0};
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("n3_seq_idx", 32'(idx3), 32'(exp_seq3[k]));
        end

        // Random traffic with occasional reset
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            req4  = 4'($urandom);
            rdy4  = ($urandom_range(0, 2) != 0);
            req3  = 3'($urandom);
            rdy3  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) req4 = '0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 The block SHALL have a parameter NUM_REQ, default 4, giving the number of requesters (legal range 1 or more).
REQ-002 The block SHALL have a parameter IDX_WIDTH, default (NUM_REQ == 1 ? 1 : $clog2(NUM_REQ)), giving the width of the binary grant index.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_i, input, NUM_REQ bits: request vector; bit i set means requester i wants service.
REQ-006 The block SHALL have port gnt_onehot_o, output, NUM_REQ bits: one-hot grant; all zero when no grant.
REQ-007 The block SHALL have port gnt_idx_o, output, IDX_WIDTH bits: binary index of the set bit of gnt_onehot_o; zero when no grant.
REQ-008 The block SHALL have port gnt_valid_o, output, 1 bit: a grant is presented.
REQ-009 The block SHALL have port gnt_ready_i, input, 1 bit: the consumer accepts the presented grant.

Function
REQ-010 The block SHALL implement two states, IDLE (gnt_valid_o=0) and GRANT (gnt_valid_o=1), with all outputs driven from registers.
REQ-011 The block SHALL keep a priority pointer ptr (0..NUM_REQ-1); arbitration selects the first set bit of req_i searching ptr, ptr+1, ... with circular wrap past NUM_REQ-1 to 0.
REQ-012 In IDLE with req_i != 0 at an edge, the block SHALL load the winner into gnt_onehot_o/gnt_idx_o and enter GRANT: one cycle latency from request to gnt_valid_o.
REQ-013 In IDLE with req_i == 0, the block SHALL stay in IDLE with outputs zero.
REQ-014 In GRANT with gnt_ready_i=0, gnt_onehot_o, gnt_idx_o and gnt_valid_o SHALL hold stable regardless of req_i (grant lock; deasserting the granted request does not revoke the grant).
REQ-015 A handshake SHALL occur at an edge where gnt_valid_o=1 and gnt_ready_i=1; on it, ptr SHALL become winner+1, with winner NUM_REQ-1 wrapping to 0 (also for non-power-of-two NUM_REQ).
REQ-016 On a handshake with req_i != 0, the block SHALL arbitrate in the same edge using the updated ptr and remain in GRANT, giving one grant per cycle under continuous ready.
REQ-017 On a handshake with req_i == 0, the block SHALL return to IDLE with gnt_onehot_o and gnt_idx_o cleared.
REQ-018 gnt_idx_o SHALL always equal the binary position of the set bit of gnt_onehot_o, and exactly one bit of gnt_onehot_o SHALL be set while gnt_valid_o=1.
REQ-019 With NUM_REQ=1, the block SHALL have gnt_idx_o constantly 0 and ptr constantly 0.
REQ-020 ptr SHALL change only on a handshake or on reset.

Reset
REQ-021 An edge with rst_ni=0 SHALL force state IDLE, ptr=0, gnt_valid_o=0, gnt_onehot_o=0 and gnt_idx_o=0, overriding any handshake or request in that cycle.
REQ-022 A reset asserted while in GRANT SHALL discard the pending grant without a handshake; the first arbitration after reset SHALL use ptr=0.

Verification
REQ-023 Reset with NUM_REQ=4: rst_ni=0 with req_i=4'b1111 -> outputs 0; release with gnt_ready_i=1 -> first grant onehot 4'b0001, idx 0, one cycle after release.
REQ-024 Fairness with NUM_REQ=4: req_i=4'b1111 held and gnt_ready_i=1 held -> idx sequence 0,1,2,3,0,1 on consecutive cycles with gnt_valid_o continuously 1.
REQ-025 Backpressure and lock: req_i=4'b0100, gnt_ready_i=0 for 5 cycles, then req_i=0 -> onehot 4'b0100 and idx 2 stable throughout; gnt_ready_i=1 -> gnt_valid_o=0 on the next cycle.
REQ-026 Wrap: after an accepted grant to idx 3, req_i=4'b1001 with gnt_ready_i=1 -> grants idx 0 then idx 3.
REQ-027 Non-power-of-two with NUM_REQ=3 (IDX_WIDTH=2): req_i=3'b111, gnt_ready_i=1 -> idx 0,1,2,0; gnt_idx_o never 3.
REQ-028 Reset mid-grant with NUM_REQ=4: gnt_valid_o=1 with idx 2, rst_ni=0 for one edge -> outputs 0; then req_i=4'b1111 -> next grant idx 0.
